// File: rtl/switch_debouncer_pkg.sv
// Shared definitions for the switch debouncer: default timing constants,
// the per-bit filter state encoding and a counter-width helper.
package switch_debouncer_pkg;

    localparam int DEFAULT_TICK_DIV     = 50000;
    localparam int DEFAULT_STABLE_TICKS = 16;

    typedef enum logic {
        STABLE  = 1'b0,
        PENDING = 1'b1
    } db_state_t;

    // Ceiling log2, floored at 1 so that counters never collapse to zero width.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        if (result < 1) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/switch_debouncer_bit.sv
// One debounced switch line: two-flop synchroniser, STABLE/PENDING filter
// with a tick counter, registered level and one-cycle rise/fall pulses.
// The accept strobe is exported so the top can register its change flag
// in the same cycle that the pulses appear.
module debounce_bit
    import switch_debouncer_pkg::*;
#(
    parameter int STABLE_TICKS = DEFAULT_STABLE_TICKS,
    parameter int CNT_W        = clog2(STABLE_TICKS)
) (
    input  logic clock,
    input  logic reset,
    input  logic tick,
    input  logic raw_in,
    output logic level,
    output logic rise,
    output logic fall,
    output logic accept
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

    logic             sync_meta;
    logic             sync;
    logic             differs;
    db_state_t        state;
    db_state_t        state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             level_next;
    logic             rise_next;
    logic             fall_next;

    assign differs = (sync != level);

    // Bring the asynchronous switch line into the clock domain; only sync is used below.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_meta <= 1'b0;
            sync      <= 1'b0;
        end else begin
            sync_meta <= raw_in;
            sync      <= sync_meta;
        end
    end

    // State register: filter state, tick counter and the registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= STABLE;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            level <= level_next;
            rise  <= rise_next;
            fall  <= fall_next;
        end
    end

    // Next-state logic; a return to equality wins over an accepting tick.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        case (state)
            STABLE: begin
                cnt_next = '0;
                if (differs) begin
                    state_next = PENDING;
                end
            end
            PENDING: begin
                if (!differs) begin
                    state_next = STABLE;
                    cnt_next   = '0;
                end else if (tick) begin
                    if (cnt == CNT_LAST) begin
                        accept     = 1'b1;
                        state_next = STABLE;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_next = STABLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Output logic: an accepted change flips the level and fires exactly one edge pulse.
    always_comb begin
        level_next = level;
        rise_next  = 1'b0;
        fall_next  = 1'b0;
        if (accept) begin
            level_next = ~level;
            rise_next  = ~level;
            fall_next  = level;
        end
    end

endmodule

// File: rtl/switch_debouncer.sv
// Debounces WIDTH raw switch lines using one shared prescaler tick and
// presents clean levels, rise/fall pulses and a combined change flag.
module switch_debouncer
    import switch_debouncer_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int TICK_DIV     = DEFAULT_TICK_DIV,
    parameter int STABLE_TICKS = DEFAULT_STABLE_TICKS
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] io_rawIn,
    output logic [WIDTH-1:0] io_switches,
    output logic [WIDTH-1:0] io_rise,
    output logic [WIDTH-1:0] io_fall,
    output logic             io_changed
);

    localparam int               PRESC_W    = clog2(TICK_DIV);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

    logic [PRESC_W-1:0] presc;
    logic               tick;
    logic [WIDTH-1:0]   accept_vec;

    assign tick = (presc == PRESC_LAST);

    // Free-running prescaler producing one tick every TICK_DIV cycles.
    always_ff @(posedge clock) begin
        if (reset) begin
            presc <= '0;
        end else if (presc == PRESC_LAST) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .STABLE_TICKS(STABLE_TICKS)
        ) u_bit (
            .clock  (clock),
            .reset  (reset),
            .tick   (tick),
            .raw_in (io_rawIn[i]),
            .level  (io_switches[i]),
            .rise   (io_rise[i]),
            .fall   (io_fall[i]),
            .accept (accept_vec[i])
        );
    end

    // Change flag registered from the accept strobes so it lines up with the pulses.
    always_ff @(posedge clock) begin
        if (reset) begin
            io_changed <= 1'b0;
        end else begin
            io_changed <= |accept_vec;
        end
    end

endmodule

// File: tb/tb_switch_debouncer.sv
// Scoreboard bench for switch_debouncer with TICK_DIV=4, STABLE_TICKS=3.
// Stimulus pushes expected change events; a monitor pops one per io_changed
// cycle and otherwise checks that outputs stay quiet at the modelled level.
module tb_switch_debouncer;

    localparam int WIDTH   = 8;
    localparam int LAT_MIN = 12;
    localparam int LAT_MAX = 15;

    typedef struct {
        logic [7:0] rise;
        logic [7:0] fall;
        logic [7:0] sw;
        int         step_cyc;
    } exp_t;

    logic             clock = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] io_rawIn;
    logic [WIDTH-1:0] io_switches;
    logic [WIDTH-1:0] io_rise;
    logic [WIDTH-1:0] io_fall;
    logic             io_changed;

    exp_t       exp_q[$];
    exp_t       mon_e;
    int         mon_lat;
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    logic       mon_en = 1'b0;
    logic [7:0] model_sw = 8'h00;

    switch_debouncer #(
        .WIDTH        (WIDTH),
        .TICK_DIV     (4),
        .STABLE_TICKS (3)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .io_rawIn    (io_rawIn),
        .io_switches (io_switches),
        .io_rise     (io_rise),
        .io_fall     (io_fall),
        .io_changed  (io_changed)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc++;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        total++;
        if (actual !== required) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, required, cyc);
        end
    endtask

    // Drive a new raw value just after a clock edge; optionally expect it to be accepted.
    task automatic applyStimulus(input logic [7:0] value, input bit expect_event);
        exp_t e;
        @(posedge clock);
        #1;
        if (expect_event) begin
            e.rise     = value & ~io_rawIn;
            e.fall     = io_rawIn & ~value;
            e.sw       = value;
            e.step_cyc = cyc;
            exp_q.push_back(e);
        end
        io_rawIn = value;
    endtask

    task automatic waitDrain(input int bound);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            @(posedge clock);
            n++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("[TB] FAIL drain_timeout: %0d events still pending, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Monitor: pop one expected event per change cycle, otherwise require quiet outputs.
    initial begin
        forever begin
            @(negedge clock);
            if (mon_en) begin
                checkOutput("rise_fall_overlap", 32'(io_rise & io_fall), 32'h0);
                if (io_changed) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("[TB] FAIL unexpected_change: rise=%0h fall=%0h sw=%0h, expected no change (cycle %0d)",
                                 io_rise, io_fall, io_switches, cyc);
                    end else begin
                        mon_e = exp_q.pop_front();
                        checkOutput("event_rise", 32'(io_rise), 32'(mon_e.rise));
                        checkOutput("event_fall", 32'(io_fall), 32'(mon_e.fall));
                        checkOutput("event_switches", 32'(io_switches), 32'(mon_e.sw));
                        mon_lat = cyc - mon_e.step_cyc;
                        total++;
                        if (mon_lat < LAT_MIN || mon_lat > LAT_MAX) begin
                            bad++;
                            $display("[TB] FAIL event_latency: got %0d cycles, expected %0d..%0d",
                                     mon_lat, LAT_MIN, LAT_MAX);
                        end
                        model_sw = mon_e.sw;
                    end
                end else begin
                    checkOutput("idle_rise", 32'(io_rise), 32'h0);
                    checkOutput("idle_fall", 32'(io_fall), 32'h0);
                    checkOutput("idle_switches", 32'(io_switches), 32'(model_sw));
                end
            end
        end
    end

    // Global time limit so the bench can never hang.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        exp_t e;
        reset    = 1'b1;
        io_rawIn = 8'h00;
        @(posedge clock);
        #1;
        mon_en = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        checkOutput("reset_switches", 32'(io_switches), 32'h0);
        checkOutput("reset_changed", 32'(io_changed), 32'h0);
        reset = 1'b0;

        $display("[TB] test 1: quiet input");
        repeat (40) @(posedge clock);

        $display("[TB] test 2: single rising step and return");
        applyStimulus(8'h01, 1'b1);
        waitDrain(30);
        repeat (5) @(posedge clock);
        applyStimulus(8'h00, 1'b1);
        waitDrain(30);
        repeat (5) @(posedge clock);

        $display("[TB] test 3: short glitch on bit 3");
        applyStimulus(8'h08, 1'b0);
        repeat (5) @(posedge clock);
        applyStimulus(8'h00, 1'b0);
        repeat (30) @(posedge clock);

        $display("[TB] test 4: multi-bit step");
        applyStimulus(8'hA5, 1'b1);
        waitDrain(30);
        repeat (5) @(posedge clock);
        applyStimulus(8'h00, 1'b1);
        waitDrain(30);
        repeat (5) @(posedge clock);

        $display("[TB] test 5: reset while bit 0 is pending");
        applyStimulus(8'h01, 1'b0);
        repeat (10) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset      = 1'b0;
        e.rise     = 8'h01;
        e.fall     = 8'h00;
        e.sw       = 8'h01;
        e.step_cyc = cyc;
        exp_q.push_back(e);
        waitDrain(30);
        repeat (5) @(posedge clock);
        applyStimulus(8'h00, 1'b1);
        waitDrain(30);
        repeat (5) @(posedge clock);

        $display("[TB] test 6: bouncing bit 1 then settle high");
        for (int k = 0; k < 5; k++) begin
            applyStimulus(8'h02, 1'b0);
            @(posedge clock);
            applyStimulus(8'h00, 1'b0);
            @(posedge clock);
        end
        applyStimulus(8'h02, 1'b1);
        waitDrain(30);
        repeat (10) @(posedge clock);

        @(negedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
